// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, datapath
// select codes, instruction field values and the condition-code evaluator.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_UNKNOWN
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_SHOUT  = 2'b10;

    localparam logic [1:0] IMM_ROT8  = 2'b00;
    localparam logic [1:0] IMM_12    = 2'b01;
    localparam logic [1:0] IMM_BR24  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // nzcv is ordered {N, Z, C, V}; the reserved 1111 code never executes.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = c;
            COND_CC: r = ~c;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = c & ~z;
            COND_LS: r = ~c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register plus the per-instruction condition result, latched in
// DECODE and held until the next DECODE.
module cond_unit
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_ni,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic       cond_load_i,
    input  logic       nz_we_i,
    input  logic       cv_we_i,
    output logic       cond_o
);

    logic [3:0] flags_q;
    logic       cond_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= FLAGS_RST;
            cond_q  <= 1'b0;
        end else begin
            if (cond_load_i) begin
                cond_q <= cond_eval(cond_i, flags_q);
            end
            if (nz_we_i) begin
                flags_q[3:2] <= alu_flags_i[3:2];
            end
            if (cv_we_i) begin
                flags_q[1:0] <= alu_flags_i[1:0];
            end
        end
    end

    assign cond_o = cond_q;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: main FSM, instruction/ALU decode and Moore
// output decode for every datapath select and enable.
module multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic        AdrSrc,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic [1:0]  ResultSrc,
    output logic        Shift,
    output logic        Retire,
    output logic        Undef
);

    state_t     state_q;
    logic [1:0] op;
    logic [3:0] cmd;
    logic       s_bit;
    logic       rd_is_pc;
    logic       cond_q;

    logic       dp_valid;
    logic [1:0] dp_alu;
    logic       no_write;
    logic       shift_op;
    logic       cv_op;
    logic [1:0] alu_dec;
    logic       in_exec;
    logic       flag_we;

    assign op       = Instr[27:26];
    assign cmd      = Instr[24:21];
    assign s_bit    = Instr[20];
    assign rd_is_pc = (Instr[15:12] == 4'hF);

    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    always_comb begin
        dp_valid = 1'b1;
        dp_alu   = ALU_ADD;
        no_write = 1'b0;
        shift_op = 1'b0;
        cv_op    = 1'b0;
        case (cmd)
            CMD_ADD: cv_op = 1'b1;
            CMD_SUB: begin dp_alu = ALU_SUB; cv_op = 1'b1; end
            CMD_AND: dp_alu = ALU_AND;
            CMD_ORR: dp_alu = ALU_ORR;
            CMD_CMP: begin dp_alu = ALU_SUB; no_write = 1'b1; cv_op = 1'b1; end
            CMD_MOV: shift_op = 1'b1;
            default: dp_valid = 1'b0;
        endcase
    end

    // Memory ops add or subtract the offset depending on the U bit.
    always_comb begin
        case (op)
            OP_MEM:  alu_dec = Instr[23] ? ALU_ADD : ALU_SUB;
            OP_DP:   alu_dec = dp_alu;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_MEM:  state_q <= S_MEMADR;
                        OP_DP:   state_q <= !dp_valid ? S_UNKNOWN :
                                            (Instr[25] ? S_EXECI : S_EXECR);
                        OP_BR:   state_q <= S_BRANCH;
                        default: state_q <= S_UNKNOWN;
                    endcase
                end
                S_MEMADR: state_q <= s_bit ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_q <= S_MEMWB;
                S_EXECR,
                S_EXECI:  state_q <= S_ALUWB;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);
    assign flag_we = in_exec && cond_q && (s_bit || (cmd == CMD_CMP));

    cond_unit #(
        .FLAGS_RST (FLAGS_RST)
    ) u_cond (
        .clk         (clk),
        .rst_ni      (reset),
        .cond_i      (Instr[31:28]),
        .alu_flags_i (ALUFlags),
        .cond_load_i (state_q == S_DECODE),
        .nz_we_i     (flag_we),
        .cv_we_i     (flag_we && cv_op),
        .cond_o      (cond_q)
    );

    // Decoded selects hold from DECODE onward so the datapath muxes stay put.
    always_comb begin
        RegSrc     = 2'b00;
        ImmSrc     = IMM_ROT8;
        ALUControl = ALU_ADD;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        AdrSrc     = 1'b0;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        Shift      = 1'b0;
        Retire     = 1'b0;
        Undef      = 1'b0;
        if (state_q != S_FETCH) begin
            RegSrc = {(op == OP_MEM) && !s_bit, op == OP_BR};
            ImmSrc = op;
        end
        if ((state_q != S_FETCH) && (state_q != S_DECODE)) begin
            ALUControl = alu_dec;
        end
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_SHOUT;
                PCWrite   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_SHOUT;
            end
            S_MEMADR: ALUSrcB = SRCB_IMM;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_q;
                Retire   = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = cond_q;
                PCWrite   = cond_q && rd_is_pc;
                Retire    = 1'b1;
            end
            S_EXECR:  Shift = shift_op;
            S_EXECI: begin
                ALUSrcB = SRCB_IMM;
                Shift   = shift_op;
            end
            S_ALUWB: begin
                RegWrite = cond_q && !no_write;
                PCWrite  = cond_q && !no_write && rd_is_pc;
                Retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_SHOUT;
                PCWrite   = cond_q;
                Retire    = 1'b1;
            end
            S_UNKNOWN: begin
                Undef  = 1'b1;
                Retire = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
